// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Lucid64 instruction fetch stage with in-flight tracking and output FIFO
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o,
  output logic [31:0] inst_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

  logic [63:0]   fetch_pc;
  logic [CW-1:0] inflight_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_cnt;

  // PC of every outstanding request, oldest at ifq_rd
  logic [63:0]   ifq_pc [DEPTH];
  logic [AW-1:0] ifq_wr;
  logic [AW-1:0] ifq_rd;

  // Returned instructions waiting for decode
  logic [63:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;

  logic [CW:0] occupancy;
  logic        grant;
  logic        resp;
  logic        drop;
  logic        push;
  logic        pop;

  // Handshake decode; credit uses registered counts only
  always_comb begin
    occupancy   = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
    imem_req_o  = ~rst_i & ~redirect_i & (occupancy < DEPTH_L);
    imem_addr_o = fetch_pc;
    grant       = imem_req_o & imem_gnt_i;
    resp        = imem_rvalid_i & (inflight_cnt != '0);
    drop        = resp & (redirect_i | (discard_cnt != '0));
    push        = resp & ~drop;
    pop         = valid_o & ~stall_i;
  end

  // FIFO head presented to decode, zeroed when nothing is buffered
  always_comb begin
    valid_o   = (fifo_cnt != '0);
    pc_o      = valid_o ? fifo_pc[fifo_rd] : '0;
    next_pc_o = valid_o ? fifo_pc[fifo_rd] + 64'd4 : '0;
    inst_o    = valid_o ? fifo_inst[fifo_rd] : '0;
  end

  // Architectural fetch PC: redirect wins, otherwise advance on grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[63:2], 2'b00};
    end else if (grant) begin
      fetch_pc <= fetch_pc + 64'd4;
    end
  end

  // In-flight queue pointers and count; grant and response together cancel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifq_wr       <= '0;
      ifq_rd       <= '0;
      inflight_cnt <= '0;
    end else begin
      if (grant) ifq_wr <= ifq_wr + AW'(1);
      if (resp)  ifq_rd <= ifq_rd + AW'(1);
      case ({grant, resp})
        2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // Request PC storage, no reset needed since reads are gated by the count
  always_ff @(posedge clk_i) begin
    if (grant) ifq_pc[ifq_wr] <= fetch_pc;
  end

  // Wrong-path responses still owed by memory after a redirect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      discard_cnt <= '0;
    end else if (redirect_i) begin
      discard_cnt <= inflight_cnt - CW'(resp);
    end else if (resp && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CW'(1);
    end
  end

  // Output FIFO control: flush on redirect, else independent push and pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else if (redirect_i) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) fifo_wr <= fifo_wr + AW'(1);
      if (pop)  fifo_rd <= fifo_rd + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Output FIFO storage, paired with the PC of the oldest outstanding request
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[fifo_wr]   <= ifq_pc[ifq_rd];
      fifo_inst[fifo_wr] <= imem_rdata_i;
    end
  end

  // Memory must never answer a request that was not issued
  always @(posedge clk_i) begin
    if (!rst_i) assert (!imem_rvalid_i || (inflight_cnt != '0));
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized bench for fetch_stage against a queue-based reference model
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [63:0] pc_o;
  logic [63:0] next_pc_o;
  logic [31:0] inst_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] m_fetch_pc;
  logic [63:0] out_pc [$];
  bit          out_live [$];
  logic [63:0] buf_pc [$];

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .next_pc_o     (next_pc_o),
    .inst_o        (inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = RESET_PC;
    out_pc.delete();
    out_live.delete();
    buf_pc.delete();
  endtask

  // One cycle: drive at negedge, check combinational view, then advance the model
  task automatic step(input bit g, input bit v, input bit s, input bit r, input logic [63:0] t);
    bit          exp_req;
    bit          do_rv;
    bit          grant;
    bit          pop;
    bit          live;
    logic [63:0] hp;
    @(negedge clk);
    do_rv         = v && (out_pc.size() != 0);
    imem_gnt_i    = g;
    imem_rvalid_i = do_rv;
    imem_rdata_i  = do_rv ? inst_of(out_pc[0]) : 32'($urandom);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    #1;
    exp_req = !r && ((out_pc.size() + buf_pc.size()) < DEPTH);
    check_eq("imem_req", imem_req_o, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr_o, m_fetch_pc);
    check_eq("valid", valid_o, buf_pc.size() != 0);
    if (buf_pc.size() != 0) begin
      check_eq("pc", pc_o, buf_pc[0]);
      check_eq("next_pc", next_pc_o, buf_pc[0] + 64'd4);
      check_eq("inst", inst_o, inst_of(buf_pc[0]));
    end
    grant = exp_req && g;
    pop   = (buf_pc.size() != 0) && !s;
    if (r) begin
      if (do_rv) begin
        void'(out_pc.pop_front());
        void'(out_live.pop_front());
      end
      foreach (out_live[i]) out_live[i] = 1'b0;
      buf_pc.delete();
      m_fetch_pc = {t[63:2], 2'b00};
    end else begin
      if (pop) void'(buf_pc.pop_front());
      if (do_rv) begin
        hp   = out_pc.pop_front();
        live = out_live.pop_front();
        if (live) buf_pc.push_back(hp);
      end
      if (grant) begin
        out_pc.push_back(m_fetch_pc);
        out_live.push_back(1'b1);
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    stall_i       = 1'b1;
    #1;
    check_eq("rst_req", imem_req_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_next_pc", next_pc_o, 0);
    check_eq("rst_inst", inst_o, 0);
    model_reset();
    repeat (cycles) @(negedge clk);
    rst_i      = 1'b0;
    imem_gnt_i = 1'b0;
  endtask

  function automatic logic [63:0] rand_target();
    case ($urandom_range(3))
      0:       return {32'($urandom), 32'($urandom)};
      1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      default: return 64'h0000_0000_8000_0000 + 64'($urandom_range(4095));
    endcase
  endfunction

  initial begin
    rst_i         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    model_reset();
    apply_reset(3);

    // Streaming with an always-granting, one-cycle memory
    repeat (12) step(1, 1, 0, 0, 0);
    // Decode stall mid-stream, then release
    repeat (5) step(1, 1, 1, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0);
    // Memory withholds grant
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0);

    // Drain, put two requests in flight, redirect to an unaligned target
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 64'h0000_0000_8000_1002);
    repeat (8) step(1, 1, 0, 0, 0);

    // Redirect coinciding with a response and a pending pop
    repeat (4) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 64'h0000_0000_8000_2000);
    repeat (6) step(1, 1, 0, 0, 0);

    // Back-to-back redirects, wrap-around target
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 64'h0000_0000_9000_0000);
    step(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB);
    repeat (10) step(1, 1, 0, 0, 0);

    // Reset with a stalled, full FIFO
    repeat (6) step(1, 1, 1, 0, 0);
    apply_reset(2);
    repeat (8) step(1, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) begin
        apply_reset(1);
      end else begin
        step($urandom_range(99) < 70, $urandom_range(99) < 65,
             $urandom_range(99) < 30, $urandom_range(99) < 5, rand_target());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
